// File: rtl/meal_scheduler.sv
// Round-robin meal/book scheduler serving four kids through a five-state FSM.
// Optional served-meal counter output enabled by defining MEAL_SCHED_STATS_EN.
module meal_scheduler #(
   parameter int unsigned COOK_CYCLES = 3,
   parameter int unsigned BOOK_DELAY  = 2
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic [3:0] req,
   output logic [3:0] meal,
   output logic [3:0] book,
   output logic [1:0] grant_id,
   output logic       busy
`ifdef MEAL_SCHED_STATS_EN
   ,
   output logic [7:0] served_cnt
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] COOK_LOAD = CNT_W'(COOK_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOOK_LOAD = CNT_W'(BOOK_DELAY - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COOK  = 3'd1,
      SERVE = 3'd2,
      WAIT  = 3'd3,
      BOOK  = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       ptr, ptr_n;
   logic [1:0]       grant_n;
   logic [3:0]       meal_n, book_n;
   logic             busy_n;
   logic [1:0]       pick;
   logic [1:0]       idx;
   logic             found;

   // First requesting kid at or above ptr, wrapping modulo 4
   always_comb begin
      pick  = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ptr_n   = ptr;
      grant_n = grant_id;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_n = COOK;
               cnt_n   = COOK_LOAD;
               grant_n = pick;
            end
         end
         COOK: begin
            if (cnt == '0) state_n = SERVE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         SERVE: begin
            state_n = WAIT;
            cnt_n   = BOOK_LOAD;
         end
         WAIT: begin
            if (cnt == '0) state_n = BOOK;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         BOOK: begin
            state_n = IDLE;
            ptr_n   = grant_id + 2'd1;
            grant_n = 2'd0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            grant_n = 2'd0;
         end
      endcase

      // Pulses are a pure decode of the next registered state and grant
      meal_n = (state_n == SERVE) ? (4'b0001 << grant_n) : 4'b0000;
      book_n = (state_n == BOOK)  ? (4'b0001 << grant_n) : 4'b0000;
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= 2'd0;
         grant_id <= 2'd0;
         meal     <= 4'b0000;
         book     <= 4'b0000;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ptr      <= ptr_n;
         grant_id <= grant_n;
         meal     <= meal_n;
         book     <= book_n;
         busy     <= busy_n;
      end
   end

`ifdef MEAL_SCHED_STATS_EN
   // Completed services, saturating at 255
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         served_cnt <= 8'd0;
      end else if (state == BOOK && served_cnt != 8'hFF) begin
         served_cnt <= served_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_meal_scheduler.sv
// Self-checking bench for meal_scheduler: timeline model plus directed scenarios.
module tb_meal_scheduler;
   localparam int C = 3;
   localparam int B = 2;

   logic       clk;
   logic       resetb;
   logic [3:0] req;
   logic [3:0] meal;
   logic [3:0] book;
   logic [1:0] grant_id;
   logic       busy;
`ifdef MEAL_SCHED_STATS_EN
   logic [7:0] served_cnt;
`endif

   int checks = 0;
   int failures = 0;

   meal_scheduler #(.COOK_CYCLES(C), .BOOK_DELAY(B)) dut (
      .clk(clk),
      .resetb(resetb),
      .req(req),
      .meal(meal),
      .book(book),
      .grant_id(grant_id),
      .busy(busy)
`ifdef MEAL_SCHED_STATS_EN
      ,
      .served_cnt(served_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++)
         if (r[(p + i) % 4]) return (p + i) % 4;
      return 0;
   endfunction

   // Timeline model: m_t counts edges since the grant edge; service ends at t=C+B+2
   bit m_active = 0;
   int m_t = 0;
   int m_ptr = 0;
   int m_g = 0;
   int m_served = 0;

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         m_active = 0; m_t = 0; m_ptr = 0; m_g = 0; m_served = 0;
      end else if (!m_active) begin
         if (req != 4'b0000) begin
            m_g = rr(req, m_ptr);
            m_active = 1;
            m_t = 0;
         end
      end else begin
         m_t++;
         if (m_t == C + B + 2) begin
            m_active = 0;
            m_ptr = (m_g + 1) % 4;
            if (m_served < 255) m_served++;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] oh;
      oh = 4'b0001 << m_g;
      check("busy", 8'(busy), 8'(m_active));
      check("grant_id", 8'(grant_id), m_active ? 8'(m_g) : 8'd0);
      check("meal", 8'(meal), (m_active && m_t == C) ? 8'(oh) : 8'd0);
      check("book", 8'(book), (m_active && m_t == C + 1 + B) ? 8'(oh) : 8'd0);
`ifdef MEAL_SCHED_STATS_EN
      check("served_cnt", served_cnt, 8'(m_served));
`endif
   end

   // Meal pulse monitor: records kid index and cycle number
   int cyc = 0;
   bit mon_en = 0;
   int pk[$];
   int pc[$];
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (mon_en && meal != 4'b0000)
         for (int i = 0; i < 4; i++)
            if (meal[i]) begin pk.push_back(i); pc.push_back(cyc); end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 30 && busy !== 1'b0; k++) step(1);
      check("idle_timeout", 8'(busy), 8'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_kids[5];
      exp_kids = '{0, 1, 2, 3, 0};
      resetb = 1'b0;
      req = 4'b1111;

      // Reset holds everything quiet despite requests
      repeat (3) begin
         step(1);
         check("rst_meal", 8'(meal), 8'd0);
         check("rst_book", 8'(book), 8'd0);
         check("rst_busy", 8'(busy), 8'd0);
         check("rst_grant", 8'(grant_id), 8'd0);
      end

      // Single request from kid 2: exact latency
      resetb = 1'b1;
      req = 4'b0100;
      step(1);
      check("s2_grant", 8'(grant_id), 8'd2);
      check("s2_busy", 8'(busy), 8'd1);
      step(2);
      check("s2_meal_early", 8'(meal), 8'd0);
      step(1);
      check("s2_meal", 8'(meal), 8'h04);
      step(1);
      check("s2_meal_end", 8'(meal), 8'd0);
      step(2);
      check("s2_book", 8'(book), 8'h04);
      step(1);
      check("s2_busy_end", 8'(busy), 8'd0);
      req = 4'b0000;

      // All kids requesting: round-robin from ptr 0, 8 cycles apart
      resetb = 1'b0;
      step(1);
      resetb = 1'b1;
      pk.delete(); pc.delete();
      mon_en = 1;
      req = 4'b1111;
      for (int k = 0; k < 100 && pk.size() < 5; k++) step(1);
      req = 4'b0000;
      mon_en = 0;
      check("s3_pulse_count", 8'(pk.size() >= 5), 8'd1);
      if (pk.size() >= 5)
         for (int i = 0; i < 5; i++) begin
            check("s3_kid", 8'(pk[i]), 8'(exp_kids[i]));
            if (i > 0) check("s3_spacing", 8'(pc[i] - pc[i-1]), 8'd8);
         end
      wait_idle();

      // Serve kid 1 with early request drop, then 0011 wraps to kid 0
      step(1);
      req = 4'b0010;
      step(1);
      check("s4_grant1", 8'(grant_id), 8'd1);
      req = 4'b0000;
      wait_idle();
      req = 4'b0011;
      step(1);
      check("s4_grant0", 8'(grant_id), 8'd0);
      req = 4'b0000;
      wait_idle();

      // Reset during COOK discards service and clears ptr
      req = 4'b1000;
      step(1);
      check("s5_grant3", 8'(grant_id), 8'd3);
      req = 4'b0000;
      step(1);
      resetb = 1'b0;
      step(1);
      check("s5_busy_rst", 8'(busy), 8'd0);
      resetb = 1'b1;
      pk.delete(); pc.delete();
      mon_en = 1;
      step(6);
      mon_en = 0;
      check("s5_no_meal", 8'(pk.size()), 8'd0);
      req = 4'b1111;
      step(1);
      check("s5_grant_after", 8'(grant_id), 8'd0);
      req = 4'b0000;
      wait_idle();

`ifdef MEAL_SCHED_STATS_EN
      // Back-to-back services saturate the counter
      req = 4'b1111;
      step(300 * (C + B + 3) + 10);
      check("s6_sat", served_cnt, 8'd255);
      step(16);
      check("s6_hold", served_cnt, 8'd255);
      req = 4'b0000;
      wait_idle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/meal_scheduler.md
MEAL_SCHEDULER -- requirements
Module: meal_scheduler

Interface
REQ-001 Parameter COOK_CYCLES, default 3, meal preparation time in cycles; legal range 1..15.
REQ-002 Parameter BOOK_DELAY, default 2, cycles between meal and book delivery; legal range 1..15.
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, resetb.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetb  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-kid meal request; bit i comes from kid i's request output.
REQ-007 meal  output  4  one-hot, one-cycle meal pulse to the granted kid.
REQ-008 book  output  4  one-hot, one-cycle book pulse to the granted kid.
REQ-009 grant_id  output  2  index of the kid currently being served; 0 when idle.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have five states: IDLE, COOK, SERVE, WAIT, BOOK.
REQ-012 State and counter SHALL update on the rising clk edge, using a 4-bit down counter cnt.
REQ-013 IDLE: if req!=0 at an edge, the scheduler SHALL latch grant_id, load cnt=COOK_CYCLES-1 and enter COOK; otherwise it stays in IDLE.
REQ-014 Grant selection SHALL be round-robin: the first set req bit searched upward from pointer ptr, modulo 4.
REQ-015 COOK: cnt SHALL decrement each edge; at cnt==0 the FSM enters SERVE, so COOK lasts exactly COOK_CYCLES cycles.
REQ-016 SERVE SHALL last one cycle with meal[grant_id]=1, load cnt=BOOK_DELAY-1, then enter WAIT.
REQ-017 WAIT SHALL decrement cnt; at cnt==0 it enters BOOK, so WAIT lasts exactly BOOK_DELAY cycles.
REQ-018 BOOK SHALL last one cycle with book[grant_id]=1, set ptr=(grant_id+1) mod 4, then return to IDLE.
REQ-019 meal and book SHALL be decoded from the registered state and grant_id only, never combinationally from req.
REQ-020 Requests SHALL be sampled only in IDLE; deasserting req[grant_id] after grant SHALL NOT abort service.
REQ-021 req changes outside IDLE SHALL be ignored until the next IDLE cycle.
REQ-022 Latency: with req sampled at edge E0, meal SHALL be high from E0+COOK_CYCLES to E0+COOK_CYCLES+1.
REQ-023 book SHALL be high from E0+COOK_CYCLES+1+BOOK_DELAY for exactly one cycle.
REQ-024 After BOOK there SHALL be at least one IDLE cycle, so the service period is COOK_CYCLES+BOOK_DELAY+3 cycles.
REQ-025 meal and book SHALL never both be nonzero, and each SHALL have at most one bit set.
REQ-026 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-027 resetb low SHALL immediately force state=IDLE, cnt=0 and ptr=0.
REQ-028 resetb low SHALL immediately force meal=0, book=0, grant_id=0 and busy=0.
REQ-029 Reset mid-service SHALL discard the service: no meal or book pulse is issued, and ptr returns to 0.

Configuration
REQ-030 Macro MEAL_SCHED_STATS_EN defined: the block SHALL add output served_cnt (8 bits), reset to 0, incremented on each BOOK cycle and saturating at 255.
REQ-031 Macro MEAL_SCHED_STATS_EN undefined: served_cnt and its logic SHALL be absent, with all other behaviour identical.

Verification (COOK_CYCLES=3, BOOK_DELAY=2)
REQ-032 Scenario 1: assert resetb=0 with req=4'b1111 -> meal=0, book=0, busy=0, grant_id=0 throughout reset.
REQ-033 Scenario 2: req=4'b0100 held from E0 -> grant_id=2 and busy=1 after E0, meal=4'b0100 in cycle E3-E4, book=4'b0100 in cycle E6-E7, busy=0 after E7.
REQ-034 Scenario 3: req=4'b1111 held continuously -> meal pulses to kids 0,1,2,3,0 in order, 8 cycles apart.
REQ-035 Scenario 4: serve kid 1, then req=4'b0011 -> kid 0 granted (ptr=2 wraps past 2,3 to 0).
REQ-036 Scenario 5: pulse resetb low during COOK -> no meal pulse, state IDLE, and the next grant search starts at 0.
REQ-037 Scenario 6: with MEAL_SCHED_STATS_EN, 300 back-to-back services -> served_cnt=255 and holding.
